// File: rtl/debug_pkg.sv
// Shared definitions for the LCD debug-display sequencer: FSM states, ASCII
// constants and nibble-to-hex conversion.
package debug_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWaitClr,
        StSel,
        StSend,
        StWaitAck,
        StDone
    } seq_state_e;

    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] ZERO  = 8'h30;

    // Uppercase hex digit for a 4-bit value.
    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? ZERO + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/debug_display_seq_if.sv
// Character/clear handshake between the debug sequencer and lcd_control.
interface debug_display_seq_if;
    logic       write_start;
    logic [7:0] data_out;
    logic       clr_lcd;
    logic       write_done;

    modport master (output write_start, output data_out, output clr_lcd, input write_done);
    modport slave  (input write_start, input data_out, input clr_lcd, output write_done);
endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic s1_q, s2_q, s3_q, pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= din;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= s2_q & ~s3_q;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/debug_display_seq.sv
// Snapshots probe channels on a trigger (or periodically) and streams them as
// "L:HH " text to lcd_control, with one-deep trigger queueing and overrun flag.
module debug_display_seq
    import debug_pkg::*;
#(
    parameter int unsigned             NUM_CH      = 4,
    parameter int unsigned             CH_W        = 8,
    parameter logic [NUM_CH*8-1:0]     LABELS      = "OYXA",
    parameter logic [23:0]             REFRESH_CYC = 24'd5_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_done,
    input  logic                   trigger,
    input  logic                   mode,
    input  logic [NUM_CH-1:0]      ch_mask,
    input  logic [NUM_CH*CH_W-1:0] ch_data,
    debug_display_seq_if.master    lcd,
    output logic                   busy,
    output logic [15:0]            frame_cnt,
    output logic                   overrun
);
    localparam int unsigned ND      = CH_W / 4;
    localparam int unsigned SEQ_LEN = ND + 3;
    localparam int unsigned IDX_W   = $clog2(NUM_CH + 1);
    localparam int unsigned CHR_W   = $clog2(SEQ_LEN + 1);

    seq_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ch_idx_q, ch_idx_d;
    logic [CHR_W-1:0]        chr_q, chr_d;
    logic [NUM_CH-1:0]       mask_sh_q, mask_sh_d;
    logic [NUM_CH*CH_W-1:0]  data_sh_q, data_sh_d;
    logic                    busy_q, busy_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    overrun_q, overrun_d;
    logic                    pending_q, pending_d;
    logic                    consumed_q, consumed_d;
    logic                    frame_mode_q, frame_mode_d;
    logic [23:0]             refresh_q, refresh_d;

    logic                    trig_p;
    logic                    write_start, clr_lcd;
    logic [7:0]              data_out, cur_char;
    logic                    found;
    logic [IDX_W-1:0]        next_ch;
    logic [CH_W-1:0]         sel_data;
    logic [7:0]              sel_label;
    logic [3:0]              nib;
    logic                    start, pend_eff, eff_mode, refresh_hit;

    edge_sync u_trig_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (trigger),
        .pulse (trig_p)
    );

    // Lowest displayed channel at or above ch_idx in the snapshot mask.
    always_comb begin
        found   = 1'b0;
        next_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_sh_q[i] && (IDX_W'(i) >= ch_idx_q)) begin
                found   = 1'b1;
                next_ch = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_label = SPACE;
        nib       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (IDX_W'(i) == ch_idx_q) begin
                sel_data  = data_sh_q[i*CH_W +: CH_W];
                sel_label = LABELS[i*8 +: 8];
            end
        end
        for (int k = 0; k < ND; k++) begin
            if (chr_q == CHR_W'(k + 2)) nib = sel_data[CH_W - 4 - 4*k +: 4];
        end
        if (chr_q == '0)                        cur_char = sel_label;
        else if (chr_q == CHR_W'(1))            cur_char = COLON;
        else if (chr_q == CHR_W'(SEQ_LEN - 1))  cur_char = SPACE;
        else                                    cur_char = nib2ascii(nib);
    end

    assign refresh_hit = (refresh_q == REFRESH_CYC - 24'd1);
    assign start = (state_q == StIdle) && init_done &&
                   (mode ? refresh_hit : (trig_p || pending_q));
    // A pending trigger being retired this cycle no longer blocks a new one.
    assign pend_eff = pending_q & ~((state_q == StDone) & consumed_q);
    assign eff_mode = (state_q == StIdle) ? mode : frame_mode_q;

    always_comb begin
        state_d      = state_q;
        ch_idx_d     = ch_idx_q;
        chr_d        = chr_q;
        mask_sh_d    = mask_sh_q;
        data_sh_d    = data_sh_q;
        busy_d       = busy_q;
        frame_cnt_d  = frame_cnt_q;
        overrun_d    = overrun_q;
        pending_d    = pend_eff;
        consumed_d   = consumed_q;
        frame_mode_d = frame_mode_q;
        refresh_d    = mode ? (refresh_hit ? 24'd0 : refresh_q + 24'd1) : 24'd0;
        write_start  = 1'b0;
        clr_lcd      = 1'b0;
        data_out     = SPACE;

        if (trig_p && !eff_mode && !((state_q == StIdle) && init_done)) begin
            if (pend_eff) overrun_d = 1'b1;
            else          pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mask_sh_d    = ch_mask;
                    data_sh_d    = ch_data;
                    busy_d       = 1'b1;
                    ch_idx_d     = '0;
                    frame_mode_d = mode;
                    consumed_d   = ~mode & pending_q;
                    state_d      = StClear;
                end
            end
            StClear: begin
                clr_lcd = 1'b1;
                state_d = StWaitClr;
            end
            StWaitClr: if (lcd.write_done) state_d = StSel;
            StSel: begin
                if (found) begin
                    ch_idx_d = next_ch;
                    chr_d    = '0;
                    state_d  = StSend;
                end else begin
                    state_d  = StDone;
                end
            end
            StSend: begin
                write_start = 1'b1;
                data_out    = cur_char;
                state_d     = StWaitAck;
            end
            StWaitAck: begin
                if (lcd.write_done) begin
                    if (chr_q == CHR_W'(SEQ_LEN - 1)) begin
                        chr_d    = '0;
                        ch_idx_d = ch_idx_q + IDX_W'(1);
                        state_d  = StSel;
                    end else begin
                        chr_d    = chr_q + CHR_W'(1);
                        state_d  = StSend;
                    end
                end
            end
            StDone: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                busy_d      = 1'b0;
                consumed_d  = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ch_idx_q     <= '0;
            chr_q        <= '0;
            mask_sh_q    <= '0;
            data_sh_q    <= '0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
            overrun_q    <= 1'b0;
            pending_q    <= 1'b0;
            consumed_q   <= 1'b0;
            frame_mode_q <= 1'b0;
            refresh_q    <= '0;
        end else begin
            state_q      <= state_d;
            ch_idx_q     <= ch_idx_d;
            chr_q        <= chr_d;
            mask_sh_q    <= mask_sh_d;
            data_sh_q    <= data_sh_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
            pending_q    <= pending_d;
            consumed_q   <= consumed_d;
            frame_mode_q <= frame_mode_d;
            refresh_q    <= refresh_d;
        end
    end

    assign lcd.write_start = write_start;
    assign lcd.clr_lcd     = clr_lcd;
    assign lcd.data_out    = data_out;
    assign busy            = busy_q;
    assign frame_cnt       = frame_cnt_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_debug_display_seq.sv
// Directed bench for debug_display_seq: two instances (8-bit x4, 16-bit x2)
// driven by a delayed-ack lcd_control model.
module tb_debug_display_seq;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst, init_done, trig0, trig1, mode0, mode1;
    logic [3:0]  mask0;
    logic [31:0] data0;
    logic [1:0]  mask1;
    logic [31:0] data1;
    logic        busy0, busy1, ov0, ov1;
    logic [15:0] fc0, fc1;

    int   n_cmp = 0, n_bad = 0, cyc = 0;
    int   ack_dly0 = 5, ack_dly1 = 5, cnt0 = 0, cnt1 = 0, clr0 = 0, clr1 = 0;
    bq_t  got0, got1;
    int   stamps[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    debug_display_seq_if lcd0 ();
    debug_display_seq_if lcd1 ();

    debug_display_seq #(
        .REFRESH_CYC (24'd100)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .trigger   (trig0),
        .mode      (mode0),
        .ch_mask   (mask0),
        .ch_data   (data0),
        .lcd       (lcd0),
        .busy      (busy0),
        .frame_cnt (fc0),
        .overrun   (ov0)
    );

    debug_display_seq #(
        .NUM_CH      (2),
        .CH_W        (16),
        .LABELS      (16'("XA")),
        .REFRESH_CYC (24'd100)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .trigger   (trig1),
        .mode      (mode1),
        .ch_mask   (mask1),
        .ch_data   (data1),
        .lcd       (lcd1),
        .busy      (busy1),
        .frame_cnt (fc1),
        .overrun   (ov1)
    );

    // lcd_control model: ack ack_dly cycles after each strobe, log everything.
    always @(negedge clk) begin
        lcd0.write_done = 1'b0;
        if (cnt0 != 0) begin
            cnt0--;
            if (cnt0 == 0) lcd0.write_done = 1'b1;
        end
        if (lcd0.write_start) begin got0.push_back(lcd0.data_out); cnt0 = ack_dly0; end
        if (lcd0.clr_lcd) begin clr0++; stamps.push_back(cyc); cnt0 = ack_dly0; end

        lcd1.write_done = 1'b0;
        if (cnt1 != 0) begin
            cnt1--;
            if (cnt1 == 0) lcd1.write_done = 1'b1;
        end
        if (lcd1.write_start) begin got1.push_back(lcd1.data_out); cnt1 = ack_dly1; end
        if (lcd1.clr_lcd) begin clr1++; cnt1 = ack_dly1; end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit which);
        if (which) trig1 = 1'b1; else trig0 = 1'b1;
        tick(2);
        trig0 = 1'b0;
        trig1 = 1'b0;
        tick(3);
    endtask

    task automatic wait_fc(input bit which, input logic [15:0] target, input int budget,
                           input string tag);
        int i = 0;
        while (((which ? fc1 : fc0) != target) && i < budget) begin
            tick(1);
            i++;
        end
        chk(tag, 64'(which ? fc1 : fc0), 64'(target));
    endtask

    task automatic chk_str(input string tag, input bq_t q, input int from, input string exp);
        for (int i = 0; i < exp.len(); i++)
            chk($sformatf("%s[%0d]", tag, i), 64'(q[from + i]), 64'(exp[i]));
    endtask

    task automatic clear_logs();
        got0.delete();
        got1.delete();
        stamps.delete();
        clr0 = 0;
        clr1 = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init_done = 1'b0; trig0 = 1'b0; trig1 = 1'b0;
        mode0 = 1'b0; mode1 = 1'b0; mask0 = '0; data0 = '0; mask1 = '0; data1 = '0;
        lcd0.write_done = 1'b0;
        lcd1.write_done = 1'b0;
        tick(3);
        chk("rst_ws", 64'(lcd0.write_start), 64'd0);
        chk("rst_clr", 64'(lcd0.clr_lcd), 64'd0);
        chk("rst_data", 64'(lcd0.data_out), 64'h20);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_fc", 64'(fc0), 64'd0);
        chk("rst_ov", 64'(ov0), 64'd0);
        rst = 1'b0;
        tick(2);

        // Full frame, all channels
        init_done = 1'b1;
        mask0 = 4'hF;
        data0 = {8'hEA, 8'hA5, 8'h00, 8'h3F};
        pulse(1'b0);
        wait_fc(1'b0, 16'd1, 1000, "f1_fc");
        tick(1);
        chk("f1_busy", 64'(busy0), 64'd0);
        chk("f1_clr", 64'(clr0), 64'd1);
        chk("f1_len", 64'(got0.size()), 64'd20);
        chk_str("f1", got0, 0, "A:3F X:00 Y:A5 O:EA ");

        // Sparse mask
        clear_logs();
        mask0 = 4'b0101;
        pulse(1'b0);
        wait_fc(1'b0, 16'd2, 1000, "f2_fc");
        chk("f2_len", 64'(got0.size()), 64'd10);
        chk_str("f2", got0, 0, "A:3F Y:A5 ");

        // Empty mask: clear only
        clear_logs();
        mask0 = 4'b0000;
        pulse(1'b0);
        wait_fc(1'b0, 16'd3, 1000, "f3_fc");
        chk("f3_clr", 64'(clr0), 64'd1);
        chk("f3_len", 64'(got0.size()), 64'd0);
        chk("f3_ov", 64'(ov0), 64'd0);

        // Three triggers in one frame, data changed mid-frame
        clear_logs();
        mask0 = 4'hF;
        pulse(1'b0);
        chk("t3_busy", 64'(busy0), 64'd1);
        data0 = {8'hFF, 8'h7E, 8'hC0, 8'h12};
        pulse(1'b0);
        chk("t3_ov_a", 64'(ov0), 64'd0);
        pulse(1'b0);
        chk("t3_ov_b", 64'(ov0), 64'd1);
        wait_fc(1'b0, 16'd5, 2000, "t3_fc");
        tick(200);
        chk("t3_fc_hold", 64'(fc0), 64'd5);
        chk("t3_clr", 64'(clr0), 64'd2);
        chk("t3_len", 64'(got0.size()), 64'd40);
        chk_str("t3a", got0, 0, "A:3F X:00 Y:A5 O:EA ");
        chk_str("t3b", got0, 20, "A:12 X:C0 Y:7E O:FF ");

        // Trigger before init_done is remembered
        clear_logs();
        init_done = 1'b0;
        pulse(1'b0);
        tick(10);
        chk("pend_busy", 64'(busy0), 64'd0);
        init_done = 1'b1;
        wait_fc(1'b0, 16'd6, 1000, "pend_fc");
        chk("pend_clr", 64'(clr0), 64'd1);

        // Free-running refresh, trigger ignored
        clear_logs();
        ack_dly0 = 1;
        mode0 = 1'b1;
        tick(150);
        pulse(1'b0);
        tick(195);
        chk("m1_frames", 64'(stamps.size()), 64'd3);
        chk("m1_gap1", 64'(stamps[1] - stamps[0]), 64'd100);
        chk("m1_gap2", 64'(stamps[2] - stamps[1]), 64'd100);
        mode0 = 1'b0;
        tick(60);
        chk("m1_idle", 64'(busy0), 64'd0);
        chk("m1_fc", 64'(fc0), 64'd9);

        // 16-bit channels
        clear_logs();
        mask1 = 2'b01;
        data1 = {16'h1234, 16'hBEEF};
        pulse(1'b1);
        wait_fc(1'b1, 16'd1, 1000, "w16_fc");
        chk("w16_len", 64'(got1.size()), 64'd7);
        chk_str("w16", got1, 0, "A:BEEF ");

        // Reset in the middle of a SEND
        clear_logs();
        mask1 = 2'b11;
        pulse(1'b1);
        for (int i = 0; i < 200 && !lcd1.write_start; i++) tick(1);
        chk("rs_seen", 64'(lcd1.write_start), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rs_ws", 64'(lcd1.write_start), 64'd0);
        chk("rs_clr", 64'(lcd1.clr_lcd), 64'd0);
        chk("rs_data", 64'(lcd1.data_out), 64'h20);
        chk("rs_busy", 64'(busy1), 64'd0);
        chk("rs_fc", 64'(fc1), 64'd0);
        chk("rs_ov0", 64'(ov0), 64'd0);
        tick(3);
        rst = 1'b0;
        clear_logs();
        tick(60);
        chk("rs_no_chars", 64'(got1.size()), 64'd0);
        chk("rs_no_clr", 64'(clr1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
